bcd_display_encoder: RTL and testbench

//  Converts the calculator's signed 32-bit binary result into the packed sign/BCD word

---
 rtl/calc_pkg.sv | 29 ++
 rtl/bcd_display_encoder_add3.sv | 15 +
 rtl/bcd_display_encoder.sv | 137 +++++++++++++
 tb/tb_bcd_display_encoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: converter state encoding, display range limits
// and keypad operator codes.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int SHIFT_BITS = 17;
  localparam int MAX_POS    = 99999;
  localparam int MIN_NEG    = -9999;
  localparam logic [3:0] SIGN_NIB = 4'hF;

  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int MAG_W      = SHIFT_BITS;
  localparam int CNT_W      = 5;

  localparam logic [4:0] OP_ADD = 5'd16;
  localparam logic [4:0] OP_SUB = 5'd15;
  localparam logic [4:0] OP_MUL = 5'd14;
  localparam logic [4:0] OP_DIV = 5'd13;
  localparam logic [4:0] OP_EQ  = 5'd17;
  localparam logic [4:0] OP_AC  = 5'd10;

endpackage

// File: rtl/bcd_display_encoder_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_display_encoder.sv
// Signed 32-bit binary to sign/BCD display word, computed by an iterative
// shift-add-3 FSM with a single start and a single valid pulse per result.
module bcd_display_encoder
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin_in,
  output logic        busy,
  output logic        valid,
  output logic [31:0] bcd_out,
  output logic        overflow
);

  state_e             state_q, state_d;
  logic [31:0]        operand_q, operand_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic [31:0]        bcd_out_q, bcd_out_d;
  logic               overflow_q, overflow_d;
  logic               valid_q, valid_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [MAG_W-1:0]   mag_abs;
  logic               out_of_range;
  logic               unused_top_adj;

  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .din  (bcd_q[4*gi +: 4]),
        .dout (bcd_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Top adjusted bit shifts out; the range check guarantees it is always zero.
  assign unused_top_adj = bcd_adj[BCD_W-1];

  // The range check runs before negation, so 0x80000000 never reaches mag_abs.
  assign out_of_range = ($signed(operand_q) > MAX_POS) || ($signed(operand_q) < MIN_NEG);
  assign mag_abs      = operand_q[31] ? (~operand_q[MAG_W-1:0] + MAG_W'(1)) : operand_q[MAG_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      operand_q  <= '0;
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_out_q  <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      operand_q  <= operand_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      bcd_out_q  <= bcd_out_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_CHECK;
      ST_CHECK: state_d = out_of_range ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    operand_d  = operand_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    bcd_out_d  = bcd_out_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) operand_d = bin_in;
      end
      ST_CHECK: begin
        ovf_d = out_of_range;
        if (!out_of_range) begin
          neg_d = operand_q[31];
          mag_d = mag_abs;
          bcd_d = '0;
          cnt_d = CNT_W'(SHIFT_BITS);
        end
      end
      ST_SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], mag_q[MAG_W-1]};
        mag_d = {mag_q[MAG_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
      end
      ST_DONE: begin
        valid_d    = 1'b1;
        overflow_d = ovf_q;
        if (ovf_q) begin
          bcd_out_d = '0;
        end else if (neg_q) begin
          bcd_out_d = {12'h0, SIGN_NIB, bcd_q[15:0]};
        end else begin
          bcd_out_d = {12'h0, bcd_q};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  assign valid    = valid_q;
  assign bcd_out  = bcd_out_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_display_encoder.sv
// Directed bench for bcd_display_encoder: a transaction-level reference model is
// compared against the DUT every cycle, plus literal checks per conversion.
module tb_bcd_display_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] bin_in = '0;
  logic        busy, valid, overflow;
  logic [31:0] bcd_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit          m_pend  = 1'b0;
  int          m_due   = -1;
  logic [31:0] m_pbcd  = '0;
  bit          m_povf  = 1'b0;
  logic [31:0] e_bcd   = '0;
  bit          e_ovf   = 1'b0;
  bit          e_valid = 1'b0;
  bit          e_busy  = 1'b0;

  bcd_display_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .valid    (valid),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Decimal digits by plain division; sign nibble replaces digit 4 for negatives.
  function automatic void ref_conv(input logic [31:0] v, output logic [31:0] b, output bit o);
    int s;
    int m;
    s = $signed(v);
    b = '0;
    o = 1'b0;
    if (s > 99999 || s < -9999) begin
      o = 1'b1;
    end else begin
      m = (s < 0) ? -s : s;
      for (int i = 0; i < 5; i++) begin
        b = b | (32'(m % 10) << (4 * i));
        m = m / 10;
      end
      if (s < 0) b[19:16] = 4'hF;
    end
  endfunction

  // Transaction model: accepted request completes 19 (or 2 on overflow) edges later.
  always @(posedge clk or negedge rst) begin : model
    int          nc;
    bit          done_now;
    logic [31:0] b;
    bit          o;
    if (!rst) begin
      m_pend  <= 1'b0;
      m_due   <= -1;
      e_bcd   <= '0;
      e_ovf   <= 1'b0;
      e_valid <= 1'b0;
      e_busy  <= 1'b0;
    end else begin
      nc = cyc + 1;
      cyc <= nc;
      done_now = m_pend && (nc == m_due);
      e_valid <= done_now;
      if (done_now) begin
        e_bcd <= m_pbcd;
        e_ovf <= m_povf;
      end
      if (start && nc > m_due) begin
        ref_conv(bin_in, b, o);
        m_pbcd <= b;
        m_povf <= o;
        m_pend <= 1'b1;
        m_due  <= nc + (o ? 2 : 19);
        e_busy <= 1'b1;
      end else begin
        if (done_now) m_pend <= 1'b0;
        e_busy <= m_pend && !done_now;
      end
    end
  end

  always @(negedge clk) begin
    total++;
    if ({busy, valid, overflow, bcd_out} !== {e_busy, e_valid, e_ovf, e_bcd}) begin
      bad++;
      $display("FAIL cycle_compare t=%0t: got busy=%b valid=%b ovf=%b bcd=%h, want busy=%b valid=%b ovf=%b bcd=%h",
               $time, busy, valid, overflow, bcd_out, e_busy, e_valid, e_ovf, e_bcd);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_valid(input int n, input int want_lat, input logic [31:0] want_bcd,
                            input bit want_ovf, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    check({tag, "_valid_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc - n), 32'(want_lat));
    check({tag, "_bcd"}, bcd_out, want_bcd);
    check({tag, "_ovf"}, 32'(overflow), 32'(want_ovf));
    $display("conv %s: bcd=%h ovf=%b lat=%0d", tag, bcd_out, overflow, cyc - n);
  endtask

  task automatic convert(input logic [31:0] v, input logic [31:0] want_bcd, input bit want_ovf,
                         input int want_lat, input string tag);
    int n;
    @(posedge clk);
    #1 start = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1 start = 1'b0;
    n = cyc;
    wait_valid(n, want_lat, want_bcd, want_ovf, tag);
  endtask

  initial begin
    int n;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_bcd", bcd_out, 32'h0);
    rst = 1'b1;

    // T1..T4
    convert(32'd0,         32'h0000_0000, 1'b0, 19, "zero");
    convert(32'd12345,     32'h0001_2345, 1'b0, 19, "p12345");
    convert(32'd99999,     32'h0009_9999, 1'b0, 19, "max_pos");
    convert(32'd1,         32'h0000_0001, 1'b0, 19, "one");
    convert(32'hFFFF_FFD6, 32'h000F_0042, 1'b0, 19, "m42");
    convert(32'hFFFF_FFFF, 32'h000F_0001, 1'b0, 19, "m1");
    convert(-32'sd9999,    32'h000F_9999, 1'b0, 19, "min_neg");
    convert(32'd100000,    32'h0,         1'b1, 2,  "ovf_hi");
    convert(-32'sd10000,   32'h0,         1'b1, 2,  "ovf_lo");
    convert(32'h8000_0000, 32'h0,         1'b1, 2,  "ovf_minint");
    convert(32'd5,         32'h0000_0005, 1'b0, 19, "five");

    // T5: start while busy is ignored; start in the valid cycle is accepted
    @(posedge clk);
    #1 start = 1'b1;
    bin_in = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    n = cyc;
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    bin_in = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    bin_in = '0;
    wait_valid(n, 19, 32'h7, 1'b0, "busy_ignore");
    start = 1'b1;
    bin_in = 32'd8;
    @(posedge clk);
    #1 start = 1'b0;
    n = cyc;
    wait_valid(n, 19, 32'h8, 1'b0, "back_to_back");

    // T6: reset mid-conversion abandons it
    @(posedge clk);
    #1 start = 1'b1;
    bin_in = 32'd500;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_bcd", bcd_out, 32'h0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (25) @(posedge clk);
    convert(32'd500, 32'h0000_0500, 1'b0, 19, "post_reset");

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
